pc_unit: RTL and testbench

- Parametrised program-counter unit for the single-cycle core; successor to the increment-only PC register.
- Selects next PC each cycle from sequential, conditional branch (eq/ne), JAL, JALR and MRET sources; supports fetch stall.
- Detects misaligned control-transfer targets and redirects to a trap vector, saving EPC.
- Small mode FSM (RUN / HANDLER / HALT) catches a second fault inside the handler and halts the core.

---
 rtl/pc_unit.sv | 56 +++++
 tb/tb_pc_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/jalr/mret selection, misaligned-target trap and RUN/HANDLER/HALT mode FSM
module pc_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h100),
  parameter int IALIGN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            branch_ne,
  input  logic            zero,
  input  logic            jump,
  input  logic            jalr,
  input  logic            mret,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            taken,
  output logic            trap,
  output logic            in_handler,
  output logic            halted
);
  localparam logic [1:0] RUN = 2'd0, HANDLER = 2'd1, HALT = 2'd2;
  localparam logic [XLEN-1:0] AMASK = XLEN'(IALIGN - 1);
  logic [1:0] state;
  logic [XLEN-1:0] target;
  assign target = jalr ? (rs1 + imm) & ~XLEN'(1) : pc + imm;
  assign taken = jalr | jump | (branch & (zero ^ branch_ne));
  assign pc_plus4 = pc + XLEN'(4);
  assign trap = taken && (target & AMASK) != '0 && !stall && state != HALT;
  assign in_handler = state == HANDLER;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
      epc <= '0;
      state <= RUN;
    end else if (!stall && state != HALT) begin
      if (in_handler && mret) begin
        pc <= epc;
        state <= RUN;
      end else if (trap) begin
        if (in_handler) state <= HALT;
        else begin
          epc <= pc;
          pc <= TRAP_VECTOR;
          state <= HANDLER;
        end
      end else pc <= taken ? target : pc_plus4;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit sequencing, redirects, traps, halt and wrap-around
module tb_pc_unit;
  logic clk = 0, rst = 1, stall = 0, branch = 0, branch_ne = 0, zero = 0, jump = 0, jalr = 0, mret = 0;
  logic [63:0] imm = 0, rs1 = 0, pc, pc_plus4, epc;
  logic taken, trap, in_handler, halted;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  pc_unit #(.XLEN(64), .RESET_VECTOR(64'h1000), .TRAP_VECTOR(64'h100), .IALIGN(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_ne(branch_ne), .zero(zero),
    .jump(jump), .jalr(jalr), .mret(mret), .imm(imm), .rs1(rs1), .pc(pc), .pc_plus4(pc_plus4),
    .epc(epc), .taken(taken), .trap(trap), .in_handler(in_handler), .halted(halted)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    stall = 0; branch = 0; branch_ne = 0; zero = 0; jump = 0; jalr = 0; mret = 0; imm = 0; rs1 = 0;
  endtask
  task automatic do_jump(input logic [63:0] off);
    idle(); jump = 1; imm = off; step(); idle();
  endtask
  initial begin
    step(); step();
    rst = 0;
    check("reset_pc", pc, 64'h1000);
    check("reset_epc", epc, 0);
    check("reset_state", {62'd0, in_handler, halted}, 0);
    step(); check("seq1", pc, 64'h1004);
    step(); check("seq2", pc, 64'h1008);
    check("pc_plus4", pc_plus4, 64'h100C);
    step(); check("seq3", pc, 64'h100C);
    do_jump(64'hFF4); check("jump_to_2000", pc, 64'h2000);
    branch = 1; zero = 1; imm = 64'h40; #1;
    check("beq_taken", taken, 1);
    check("beq_no_trap", trap, 0);
    step(); idle(); check("beq_pc", pc, 64'h2040);
    do_jump(-64'h40); check("back_2000", pc, 64'h2000);
    branch = 1; branch_ne = 1; zero = 1; imm = 64'h40; #1;
    check("bne_not_taken", taken, 0);
    step(); idle(); check("bne_pc", pc, 64'h2004);
    do_jump(64'hFFC); check("to_3000", pc, 64'h3000);
    jalr = 1; rs1 = 64'h5001; #1;
    check("jalr_taken", taken, 1);
    check("jalr_no_trap", trap, 0);
    step(); idle(); check("jalr_pc", pc, 64'h5000);
    do_jump(-64'h1000); check("to_4000", pc, 64'h4000);
    jump = 1; imm = 6; #1;
    check("mis_trap", trap, 1);
    step(); idle();
    check("trap_pc", pc, 64'h100);
    check("trap_epc", epc, 64'h4000);
    check("trap_handler", in_handler, 1);
    mret = 1; step(); idle();
    check("mret_pc", pc, 64'h4000);
    check("mret_run", in_handler, 0);
    mret = 1; step(); idle();
    check("mret_ignored_pc", pc, 64'h4004);
    check("mret_ignored_state", in_handler, 0);
    do_jump(6);
    check("trap2_pc", pc, 64'h100);
    check("trap2_epc", epc, 64'h4004);
    stall = 1; jump = 1; imm = 64'h10; step(); step();
    check("stall_pc", pc, 64'h100);
    mret = 1; imm = 2; #1;
    check("stall_no_trap", trap, 0);
    step(); idle();
    check("stall_mret_pc", pc, 64'h100);
    check("stall_mret_state", in_handler, 1);
    jump = 1; imm = 2; #1;
    check("nested_trap", trap, 1);
    step(); idle();
    check("halt_flag", halted, 1);
    check("halt_pc", pc, 64'h100);
    check("halt_epc", epc, 64'h4004);
    jump = 1; imm = 2; mret = 1; #1;
    check("halt_trap0", trap, 0);
    check("halt_taken", taken, 1);
    step(); step(); idle();
    check("halt_frozen_pc", pc, 64'h100);
    check("halt_frozen", {62'd0, in_handler, halted}, 1);
    rst = 1; step(); rst = 0;
    check("recover_pc", pc, 64'h1000);
    check("recover_state", {62'd0, in_handler, halted}, 0);
    check("recover_epc", epc, 0);
    jump = 1; imm = 64'h100; jalr = 1; rs1 = 64'h8000; imm = 1; step(); idle();
    check("jalr_over_jump", pc, 64'h8000);
    jalr = 1; rs1 = 64'hFFFF_FFFF_FFFF_FFFC; step(); idle();
    check("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("top_plus4", pc_plus4, 0);
    step(); check("wrap_pc", pc, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
